np_uart_rx: RTL and testbench

- Serial receiver stage directly downstream of the SERIAL_RX pin of the top-level FPGA wrapper.
- Deserialises 8N1 asynchronous serial frames into parallel bytes.
- Presents each byte on a valid/ready handshake to the command/datapath logic inside the wrapper.
- Reports framing errors and overruns as single-cycle pulses.

---
 rtl/np_uart_rx_pkg.sv | 25 ++
 rtl/np_uart_rx_if.sv | 34 +++
 rtl/np_bit_sync.sv | 35 +++
 rtl/np_uart_rx.sv | 138 +++++++++++++
 tb/tb_np_uart_rx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/np_uart_rx_pkg.sv
// ============================================================================
// Module      : np_uart_rx_pkg
// Description : Shared UART timing constants and receiver state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package np_uart_rx_pkg;

    localparam int CLK_FREQ_HZ          = 100_000_000;
    localparam int BAUD                 = 115_200;
    // Shared with np_uart_tx so both directions derive identical bit timing.
    localparam int DEFAULT_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/np_uart_rx_if.sv
// ============================================================================
// Module      : np_uart_rx_if
// Description : Byte valid/ready handshake plus error pulses from the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface np_uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data,
        output data_valid,
        output frame_err,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        input  frame_err,
        input  overrun,
        output data_ready
    );
endinterface

`default_nettype wire

// File: rtl/np_bit_sync.sv
// ============================================================================
// Module      : np_bit_sync
// Description : Two-flop synchroniser for an asynchronous pin, reset value set
//               by parameter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module np_bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d,
    output logic      q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/np_uart_rx.sv
// ============================================================================
// Module      : np_uart_rx
// Description : 8N1-style serial receiver with a one-entry valid/ready holding
//               register and single-cycle framing/overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module np_uart_rx
    import np_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire logic     serial_rx,
    np_uart_rx_if.master  rx_bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] c_bit_last  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] c_bits_last = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    rx_state_t            r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_done;
    logic                 r_frame_err;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_overrun;

    np_bit_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (serial_rx),
        .q     (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                    if (!w_rx_s) r_state <= ST_START;
                end
                ST_START: begin
                    // Mid-start-bit check rejects short glitches silently.
                    if (r_clk_cnt == c_half_last) begin
                        r_clk_cnt <= '0;
                        r_state   <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_clk_cnt == c_bit_last) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_bits_last) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (r_clk_cnt == c_bit_last) begin
                        r_clk_cnt <= '0;
                        if (w_rx_s) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_rx_s) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A pop and a fresh byte on the same edge keep valid high with new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_valid || rx_bus.data_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_bus.data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_bus.data       = r_data;
    assign rx_bus.data_valid = r_valid;
    assign rx_bus.frame_err  = r_frame_err;
    assign rx_bus.overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_np_uart_rx.sv
// ============================================================================
// Module      : tb_np_uart_rx
// Description : Directed self-checking bench for np_uart_rx at 16 clocks/bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_np_uart_rx;

    localparam int CPB = 16;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic serial_rx = 1'b1;

    np_uart_rx_if #(.DATA_BITS(8)) bus ();

    np_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .serial_rx (serial_rx),
        .rx_bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event monitor, sampled on the falling edge.
    int         cyc = 0;
    int         rise_cnt = 0, fall_cnt = 0, hi_cnt = 0;
    int         ovr_cnt = 0, ferr_cnt = 0, chg_cnt = 0, last_rise_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] prev_data = 8'h00;
    logic       prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid && !prev_valid) begin
            rise_cnt      <= rise_cnt + 1;
            last_rise_cyc <= cyc;
            last_data     <= bus.data;
        end
        if (!bus.data_valid && prev_valid) fall_cnt <= fall_cnt + 1;
        if (bus.data_valid) hi_cnt <= hi_cnt + 1;
        if (bus.data_valid && prev_valid && (bus.data !== prev_data)) begin
            chg_cnt   <= chg_cnt + 1;
            last_data <= bus.data;
        end
        if (bus.overrun)   ovr_cnt  <= ovr_cnt + 1;
        if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
        prev_valid <= bus.data_valid;
        prev_data  <= bus.data;
    end

    int s_rise, s_fall, s_hi, s_ovr, s_ferr, s_chg;
    int t0, dummy;

    task automatic snap();
        s_rise = rise_cnt; s_fall = fall_cnt; s_hi = hi_cnt;
        s_ovr  = ovr_cnt;  s_ferr = ferr_cnt; s_chg = chg_cnt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int start_cyc);
        serial_rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            serial_rx = b[i];
            repeat (CPB) tick();
        end
        serial_rx = stop_bit;
        repeat (CPB) tick();
    endtask

    initial begin
        bus.data_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        check("rst_data",  32'(bus.data),       32'h00);
        check("rst_ferr",  32'(bus.frame_err),  32'd0);
        check("rst_ovr",   32'(bus.overrun),    32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_valid", 32'(bus.data_valid), 32'd0);

        // Single frame, consumer always ready; latency counted from the
        // first clock edge that registers the falling line.
        bus.data_ready = 1'b1;
        snap();
        send_byte(8'hA5, 1'b1, t0);
        repeat (4) tick();
        check("a5_rise",    32'(rise_cnt - s_rise),        32'd1);
        check("a5_data",    32'(last_data),                32'hA5);
        check("a5_latency", 32'(last_rise_cyc - (t0 + 1)), 32'd155);
        check("a5_hi_cyc",  32'(hi_cnt - s_hi),            32'd1);
        check("a5_ferr",    32'(ferr_cnt - s_ferr),        32'd0);
        check("a5_ovr",     32'(ovr_cnt - s_ovr),          32'd0);

        // Three back-to-back frames with no consumer: two overruns.
        bus.data_ready = 1'b0;
        snap();
        send_byte(8'h3C, 1'b1, dummy);
        send_byte(8'h00, 1'b1, dummy);
        send_byte(8'hFF, 1'b1, dummy);
        repeat (4) tick();
        check("ovr_data",  32'(bus.data),          32'h3C);
        check("ovr_valid", 32'(bus.data_valid),    32'd1);
        check("ovr_count", 32'(ovr_cnt - s_ovr),   32'd2);
        check("ovr_rise",  32'(rise_cnt - s_rise), 32'd1);
        check("ovr_held",  32'(chg_cnt - s_chg),   32'd0);
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        tick();
        check("pop_valid", 32'(bus.data_valid), 32'd0);

        // Accept the held byte on the exact edge the next byte is loaded.
        send_byte(8'h12, 1'b1, dummy);
        repeat (4) tick();
        check("hold12_data", 32'(bus.data), 32'h12);
        snap();
        fork
            send_byte(8'h55, 1'b1, dummy);
            begin
                repeat (155) tick();
                bus.data_ready = 1'b1;
                tick();
                bus.data_ready = 1'b0;
            end
        join
        repeat (4) tick();
        check("swap_data",  32'(bus.data),          32'h55);
        check("swap_valid", 32'(bus.data_valid),    32'd1);
        check("swap_fall",  32'(fall_cnt - s_fall), 32'd0);
        check("swap_ovr",   32'(ovr_cnt - s_ovr),   32'd0);
        bus.data_ready = 1'b1;
        tick();
        check("swap_pop", 32'(bus.data_valid), 32'd0);

        // Short low glitch is rejected, then a real frame.
        snap();
        serial_rx = 1'b0;
        repeat (5) tick();
        serial_rx = 1'b1;
        repeat (40) tick();
        check("glitch_rise", 32'(rise_cnt - s_rise), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - s_ferr), 32'd0);
        send_byte(8'h81, 1'b1, dummy);
        repeat (4) tick();
        check("g81_rise", 32'(rise_cnt - s_rise), 32'd1);
        check("g81_data", 32'(last_data),         32'h81);

        // Low stop bit followed by a held break.
        snap();
        send_byte(8'h7E, 1'b0, dummy);
        repeat (100) tick();
        serial_rx = 1'b1;
        repeat (20) tick();
        check("brk_ferr", 32'(ferr_cnt - s_ferr), 32'd1);
        check("brk_rise", 32'(rise_cnt - s_rise), 32'd0);
        check("brk_ovr",  32'(ovr_cnt - s_ovr),   32'd0);
        bus.data_ready = 1'b0;
        snap();
        send_byte(8'h42, 1'b1, dummy);
        repeat (4) tick();
        check("b42_rise",  32'(rise_cnt - s_rise),  32'd1);
        check("b42_data",  32'(bus.data),           32'h42);
        check("b42_valid", 32'(bus.data_valid),     32'd1);
        check("b42_ferr",  32'(ferr_cnt - s_ferr),  32'd0);

        // Reset in the middle of data bit 4 while 0x42 is still held.
        fork
            send_byte(8'hC3, 1'b1, dummy);
            begin
                repeat (88) tick();
                rst_n = 1'b0;
                #2;
                check("mid_rst_valid", 32'(bus.data_valid), 32'd0);
                check("mid_rst_data",  32'(bus.data),       32'h00);
                check("mid_rst_ferr",  32'(bus.frame_err),  32'd0);
                check("mid_rst_ovr",   32'(bus.overrun),    32'd0);
                repeat (3) tick();
                rst_n = 1'b1;
                bus.data_ready = 1'b1;
            end
        join
        repeat (300) tick();
        snap();
        send_byte(8'h99, 1'b1, dummy);
        repeat (4) tick();
        check("r99_rise", 32'(rise_cnt - s_rise), 32'd1);
        check("r99_data", 32'(last_data),         32'h99);
        check("r99_ferr", 32'(ferr_cnt - s_ferr), 32'd0);
        check("r99_ovr",  32'(ovr_cnt - s_ovr),   32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
